// File: rtl/serial_pat_pkg.sv
// Shared definitions for the serial pattern generator and the detector blocks.
package serial_pat_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, MSB-out shift register; zeros are shifted in at the LSB.
module pattern_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Load has priority over shift; a shift moves the next bit into the MSB.
  always_ff @(posedge clk) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: MSB-first frames, repeated with an idle gap.
module serial_pattern_gen
  import serial_pat_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [BW-1:0]    bit_cnt;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;
  logic             sr_msb;

  logic last_bit, more_reps, gap_end;
  assign last_bit  = (bit_cnt == '0);
  assign more_reps = (rep_cnt != '0);
  assign gap_end   = (gap_cnt == CNT_W'(1));

  // The MSB goes straight to x_out on the frame's first edge, so the shift
  // register is loaded with the remaining bits already advanced by one.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = {pat_q[WIDTH-2:0], 1'b0};
    case (state)
      IDLE: begin
        if (start) begin
          sr_load = 1'b1;
          sr_din  = {pattern[WIDTH-2:0], 1'b0};
        end
      end
      SHIFT: begin
        if (!last_bit)                      sr_shift = 1'b1;
        else if (more_reps && gap_q == '0)  sr_load  = 1'b1;
      end
      GAP:     sr_load = gap_end;
      default: ;
    endcase
  end

  pattern_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // Control FSM with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      rep_cnt     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      x_out       <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            rep_cnt     <= repeat_cnt;
            gap_q       <= gap;
            bit_cnt     <= BW'(WIDTH-1);
            state       <= SHIFT;
            x_out       <= pattern[WIDTH-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt     <= bit_cnt - 1'b1;
            x_out       <= sr_msb;
            frame_start <= 1'b0;
          end else if (more_reps && gap_q != '0) begin
            state       <= GAP;
            gap_cnt     <= gap_q;
            x_out       <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
          end else if (more_reps) begin
            // back-to-back restart, no bubble
            rep_cnt     <= rep_cnt - 1'b1;
            bit_cnt     <= BW'(WIDTH-1);
            x_out       <= pat_q[WIDTH-1];
            frame_start <= 1'b1;
          end else begin
            state       <= DONE;
            x_out       <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b1;
          end
        end
        GAP: begin
          if (gap_end) begin
            state       <= SHIFT;
            rep_cnt     <= rep_cnt - 1'b1;
            bit_cnt     <= BW'(WIDTH-1);
            x_out       <= pat_q[WIDTH-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt     <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomized self-checking bench for serial_pattern_gen.
module tb_serial_pattern_gen;

  localparam int W = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic [C-1:0] repeat_cnt;
  logic [C-1:0] gap;
  logic         x_out, bit_valid, frame_start, busy, done;

  serial_pattern_gen #(.WIDTH(W), .CNT_W(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .gap         (gap),
    .x_out       (x_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] expq[$];   // per cycle: {x_out, bit_valid, frame_start, busy, done}
  logic [4:0] obs;
  assign obs = {x_out, bit_valid, frame_start, busy, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got[4:0], exp[4:0], $time);
    end
  endtask

  // Expected cycle-by-cycle stream for one accepted transaction, from cycle 0
  // (the accept edge) through the DONE cycle.
  function automatic void build(input logic [W-1:0] p, input int r, input int g);
    expq.delete();
    for (int k = 0; k <= r; k++) begin
      for (int b = W-1; b >= 0; b--)
        expq.push_back({p[b], 1'b1, (b == W-1), 1'b1, 1'b0});
      if (k < r)
        for (int j = 0; j < g; j++) expq.push_back(5'b00010);
    end
    expq.push_back(5'b00011);
  endfunction

  task automatic accept(input logic [W-1:0] p, input int r, input int g);
    @(negedge clk);
    start = 1'b1; pattern = p; repeat_cnt = C'(r); gap = C'(g);
    @(posedge clk); #1;
    build(p, r, g);
  endtask

  // mode 0: quiet inputs, 1: random start/field noise, 2: hold start with 0110
  task automatic play(input int mode, input int abort_at);
    for (int i = 0; i < expq.size(); i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("abort_outs", {27'd0, obs}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_abort", {27'd0, obs}, 32'd0);
        return;
      end
      chk($sformatf("cyc%0d", i), {27'd0, obs}, {27'd0, expq[i]});
      @(negedge clk);
      case (mode)
        1: begin
          start      = 1'($urandom_range(0, 1));
          pattern    = W'($urandom);
          repeat_cnt = C'($urandom);
          gap        = C'($urandom);
        end
        2: begin
          start = 1'b1; pattern = 4'b0110; repeat_cnt = '0; gap = '0;
        end
        default: start = 1'b0;
      endcase
      @(posedge clk); #1;
    end
  endtask

  // Two quiet idle cycles after a transaction.
  task automatic idle_check(input string tag);
    chk({tag, "_idle0"}, {27'd0, obs}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle1"}, {27'd0, obs}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {27'd0, obs}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_reset", {27'd0, obs}, 32'd0);

    // single frame
    accept(4'b1101, 0, 0); play(0, -1); idle_check("t1");
    // back-to-back repetitions
    accept(4'b1011, 2, 0); play(0, -1); idle_check("t2");
    // repetitions with gap
    accept(4'b1001, 1, 3); play(0, -1); idle_check("t3");
    // random start/field noise while busy must not disturb the frame
    accept(4'b1010, 2, 2); play(1, -1); idle_check("t4");
    // start held through DONE: accepted only in the first IDLE cycle
    accept(4'b1100, 1, 1); play(2, -1);
    chk("hold_idle", {27'd0, obs}, 32'd0);
    @(posedge clk); #1;
    build(4'b0110, 0, 0);
    play(0, -1); idle_check("t5");
    // reset during bit 2 of the second repetition, then a clean run
    accept(4'b1101, 2, 1); play(0, W + 1 + 1);
    accept(4'b1101, 0, 0); play(0, -1); idle_check("t6");
    // maximum repetition count
    accept(4'b1111, (1 << C) - 1, 0); play(0, -1); idle_check("t7");
    // random transactions
    for (int t = 0; t < 12; t++) begin
      accept(W'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      play(1, -1);
      idle_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
